// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the async FIFO write port among NREQ producers.
// Define FIFO_ARB_BURST_EN to hold each grant for up to MAX_BURST consecutive beats.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 4,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [DSIZE-1:0]      wdata,
    output logic                  winc,
    input  logic                  wfull,
    output logic [IDW-1:0]        grant_id,
    output logic                  grant_vld,
    output logic [15:0]           wr_count
);
    if (NREQ < 2 || MAX_BURST < 1) begin : g_param_check
        $error("fifo_wr_arbiter: NREQ must be >= 2 and MAX_BURST >= 1");
    end

    logic [IDW-1:0] ptr_q, ptr_d, rr_sel, sel;
    logic           found, accept;
    logic [15:0]    wr_count_q;

    // First valid requester after the last served one, wrapping modulo NREQ
    always_comb begin
        rr_sel = ptr_q;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
                rr_sel = IDW'((int'(ptr_q) + k) % NREQ);
                found  = 1'b1;
            end
        end
    end

    assign grant_vld = |req_valid;
    assign grant_id  = grant_vld ? sel : '0;
    assign accept    = wrst_n & grant_vld & req_valid[sel] & ~wfull;
    assign winc      = accept;
    assign wr_count  = wr_count_q;

    always_comb begin
        wdata     = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == i[IDW-1:0]) begin
                wdata        = req_data[i*DSIZE +: DSIZE];
                req_ready[i] = wrst_n & ~wfull & grant_vld;
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, BURST} state_t;
    state_t         state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [BW-1:0]  beat_cnt_q, beat_cnt_d;

    assign sel = (state_q == BURST) ? owner_q : rr_sel;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        ptr_d      = ptr_q;
        if (state_q == IDLE) begin
            if (accept && MAX_BURST > 1) begin
                state_d    = BURST;
                owner_d    = sel;
                beat_cnt_d = BW'(1);
            end else if (accept) begin
                ptr_d = sel;
            end
        end else if (!req_valid[owner_q]) begin
            // Owner went quiet: give up the grant, costing one idle cycle
            state_d = IDLE;
            ptr_d   = owner_q;
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + BW'(1);
            if (int'(beat_cnt_q) + 1 == MAX_BURST) begin
                state_d = IDLE;
                ptr_d   = owner_q;
            end
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    assign sel   = rr_sel;
    assign ptr_d = accept ? sel : ptr_q;
`endif

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            ptr_q      <= IDW'(NREQ - 1);
            wr_count_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wr_count_q <= wr_count_q + 16'(accept);
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vector bench for fifo_wr_arbiter (4 requesters, 8-bit data).
// Burst expectations are selected when FIFO_ARB_BURST_EN is defined.
module tb_fifo_wr_arbiter;
    logic        wclk = 1'b0;
    logic        wrst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  wdata;
    logic        winc;
    logic        wfull;
    logic [1:0]  grant_id;
    logic        grant_vld;
    logic [15:0] wr_count;

    int n_chk = 0;
    int n_fail = 0;

    fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .MAX_BURST(4)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .wdata(wdata), .winc(winc), .wfull(wfull),
        .grant_id(grant_id), .grant_vld(grant_vld), .wr_count(wr_count)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [3:0] rv;
        logic       wf;
        logic       winc;
        logic [3:0] rdy;
        logic [1:0] gid;
    } vec_t;

    vec_t vs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        req_valid = 4'hF;
        wfull = 1'b0;
        #1;
        chk("rst_winc", {31'd0, winc}, 32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
        @(negedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    function automatic vec_t v(logic [3:0] rv, logic wf, logic wi, logic [3:0] rdy, logic [1:0] gid);
        vec_t r;
        r.rv = rv; r.wf = wf; r.winc = wi; r.rdy = rdy; r.gid = gid;
        return r;
    endfunction

    function automatic logic [1:0] fill_id(int n);
`ifdef FIFO_ARB_BURST_EN
        return 2'((n / 4) % 2);
`else
        return 2'(n % 2);
`endif
    endfunction

    initial begin
        int exp_cnt;
        int nw;
        logic [7:0] fq[$];
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'hA0 + 8'(i);
`ifdef FIFO_ARB_BURST_EN
        for (int i = 0; i < 8; i++) vs.push_back(v(4'b0011, 0, 1, (i < 4) ? 4'b0001 : 4'b0010, (i < 4) ? 2'd0 : 2'd1));
        vs.push_back(v(4'b0011, 0, 1, 4'b0001, 2'd0));
        vs.push_back(v(4'b0011, 0, 1, 4'b0001, 2'd0));
        vs.push_back(v(4'b0010, 0, 0, 4'b0001, 2'd0));
        vs.push_back(v(4'b0010, 0, 1, 4'b0010, 2'd1));
        vs.push_back(v(4'b0010, 1, 0, 4'b0000, 2'd1));
        vs.push_back(v(4'b0010, 0, 1, 4'b0010, 2'd1));
        vs.push_back(v(4'b0000, 0, 0, 4'b0000, 2'd0));
`else
        for (int i = 0; i < 10; i++) vs.push_back(v(4'hF, 0, 1, 4'b0001 << (i % 4), 2'(i % 4)));
        vs.push_back(v(4'hF, 1, 0, 4'b0000, 2'd2));
        vs.push_back(v(4'hF, 1, 0, 4'b0000, 2'd2));
        vs.push_back(v(4'hF, 0, 1, 4'b0100, 2'd2));
        vs.push_back(v(4'hF, 0, 1, 4'b1000, 2'd3));
        for (int i = 0; i < 4; i++) vs.push_back(v(4'b1010, 0, 1, (i % 2) ? 4'b1000 : 4'b0010, (i % 2) ? 2'd3 : 2'd1));
        vs.push_back(v(4'b0000, 0, 0, 4'b0000, 2'd0));
        vs.push_back(v(4'b0100, 0, 1, 4'b0100, 2'd2));
        vs.push_back(v(4'b0100, 0, 1, 4'b0100, 2'd2));
`endif
        do_reset();
        exp_cnt = 0;
        foreach (vs[k]) begin
            req_valid = vs[k].rv;
            wfull = vs[k].wf;
            #2;
            chk($sformatf("winc[%0d]", k), {31'd0, winc}, {31'd0, vs[k].winc});
            chk($sformatf("ready[%0d]", k), {28'd0, req_ready}, {28'd0, vs[k].rdy});
            chk($sformatf("grant_vld[%0d]", k), {31'd0, grant_vld}, {31'd0, |vs[k].rv});
            chk($sformatf("grant_id[%0d]", k), {30'd0, grant_id}, {30'd0, vs[k].gid});
            if (vs[k].winc) chk($sformatf("wdata[%0d]", k), {24'd0, wdata}, 32'hA0 + 32'(vs[k].gid));
            chk($sformatf("wr_count[%0d]", k), {16'd0, wr_count}, 32'(exp_cnt));
            exp_cnt += int'(vs[k].winc);
            @(negedge wclk);
        end
        // Asynchronous reset in the middle of an accepted beat
        req_valid = 4'hF;
        wfull = 1'b0;
        #2;
        chk("mid_winc_before", {31'd0, winc}, 32'd1);
        wrst_n = 1'b0;
        #1;
        chk("mid_winc", {31'd0, winc}, 32'd0);
        chk("mid_ready", {28'd0, req_ready}, 32'd0);
        chk("mid_wr_count", {16'd0, wr_count}, 32'd0);
        @(negedge wclk);
        wrst_n = 1'b1;
        #2;
        chk("post_rst_grant", {30'd0, grant_id}, 32'd0);
        chk("post_rst_winc", {31'd0, winc}, 32'd1);
        // Fill a modelled 16-deep FIFO with no reads
        do_reset();
        nw = 0;
        for (int c = 0; c < 20; c++) begin
            wfull = (fq.size() == 16);
            req_valid = 4'b0011;
            #2;
            if (winc) begin
                fq.push_back(wdata);
                nw++;
            end
            @(negedge wclk);
        end
        wfull = (fq.size() == 16);
        #2;
        chk("fill_beats", 32'(nw), 32'd16);
        chk("fill_wr_count", {16'd0, wr_count}, 32'd16);
        chk("fill_full_winc", {31'd0, winc}, 32'd0);
        for (int n = 0; n < 16 && fq.size() > 0; n++) begin
            logic [7:0] d;
            d = fq.pop_front();
            chk($sformatf("fill_order[%0d]", n), {24'd0, d}, 32'hA0 + 32'(fill_id(n)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
